// File: rtl/sp_ram_fifo_ctrl_if.sv
// rtl/sp_ram_fifo_ctrl_if.sv - stream and single-port RAM signals of the FIFO controller
// master = controller side, slave = producer/consumer/RAM side.
interface sp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  ram_enable_write;
  logic                  ram_ctrl_write;
  logic                  ram_enable_read;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_write;
  logic [DATA_WIDTH-1:0] ram_data_read;

  modport master (
    input  in_valid, in_data, out_ready, ram_data_read,
    output in_ready, out_valid, out_data,
           ram_enable_write, ram_ctrl_write, ram_enable_read, ram_addr, ram_data_write
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_data_read,
    input  in_ready, out_valid, out_data,
           ram_enable_write, ram_ctrl_write, ram_enable_read, ram_addr, ram_data_write
  );
endinterface

// File: rtl/sp_ram_fifo_ctrl.sv
// rtl/sp_ram_fifo_ctrl.sv - FIFO controller over a single-port RAM with a 2-entry read buffer
// Optional almost_full output enabled by SP_FIFO_AFULL_EN.
module sp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int MEM_SIZE     = 1024,
  parameter int ADDR_WIDTH   = (MEM_SIZE == 1) ? 1 : $clog2(MEM_SIZE),
  parameter int AFULL_THRESH = MEM_SIZE - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sp_ram_fifo_ctrl_if.master    bus,
  output logic [ADDR_WIDTH:0]   fill
`ifdef SP_FIFO_AFULL_EN
  ,
  output logic                  almost_full
`endif
);
  localparam logic [ADDR_WIDTH:0]   FILL_MAX = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_inflight;
  logic                  prio_rd;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] obuf_head;
  logic [DATA_WIDTH-1:0] obuf_tail;

  logic       full;
  logic       empty;
  logic       pop;
  logic [2:0] pending;
  logic       rd_req;
  logic       wr_go;
  logic       rd_go;

  function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full  = (fill == FILL_MAX);
  assign empty = (fill == '0);
  assign pop   = bus.out_valid && bus.out_ready;

  // Words that will sit in the buffer once the outstanding read lands; cannot underflow
  // because a pop implies occ >= 1.
  assign pending = {1'b0, occ} + {2'b00, rd_inflight} - {2'b00, pop};
  assign rd_req  = !empty && (pending < 3'd2);

  assign bus.in_ready = rst_n && !full && !(rd_req && prio_rd);
  assign wr_go        = bus.in_valid && bus.in_ready;
  assign rd_go        = rd_req && !wr_go;

  assign bus.ram_enable_write = wr_go;
  assign bus.ram_ctrl_write   = wr_go;
  assign bus.ram_enable_read  = rd_go;
  assign bus.ram_addr         = wr_go ? wr_ptr : rd_ptr;
  assign bus.ram_data_write   = wr_go ? bus.in_data : '0;

  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = obuf_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      rd_inflight <= 1'b0;
      prio_rd     <= 1'b0;
      occ         <= 2'd0;
      obuf_head   <= '0;
      obuf_tail   <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr  <= next_ptr(wr_ptr);
        fill    <= fill + 1'b1;
        prio_rd <= 1'b1;
      end else if (rd_go) begin
        rd_ptr  <= next_ptr(rd_ptr);
        fill    <= fill - 1'b1;
        prio_rd <= 1'b0;
      end
      rd_inflight <= rd_go;

      // Capture lands at the tail after any pop has shifted the head out.
      case ({pop, rd_inflight})
        2'b01: begin
          if (occ == 2'd0) obuf_head <= bus.ram_data_read;
          else             obuf_tail <= bus.ram_data_read;
          occ <= occ + 2'd1;
        end
        2'b10: begin
          obuf_head <= obuf_tail;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            obuf_head <= bus.ram_data_read;
          end else begin
            obuf_head <= obuf_tail;
            obuf_tail <= bus.ram_data_read;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SP_FIFO_AFULL_EN
  localparam logic [ADDR_WIDTH:0] AFULL_LEVEL = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (fill >= AFULL_LEVEL);
  end
`endif

endmodule
